// File: rtl/idx_load_sched.sv
// Index-load job scheduler: accepts a load job, pulses the index loader, issues one
// DDR read command, then waits for the loader to report done (or times out).
module idx_load_sched #(
    parameter int PE_NUM    = 32,
    parameter int IDX_BATCH = 16,
    parameter int AW        = 32,
    parameter int TIMEOUT   = 4096
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              job_valid,
    output logic              job_ready,
    input  logic [AW-1:0]     job_addr,
    input  logic [3:0]        job_mode,
    input  logic [7:0]        job_idx_num,
    input  logic [PE_NUM-1:0] job_mask,

    output logic              rd_cmd_valid,
    input  logic              rd_cmd_ready,
    output logic [AW-1:0]     rd_cmd_addr,
    output logic [4:0]        rd_cmd_len,

    output logic              ld_start,
    output logic [3:0]        ld_mode,
    output logic [7:0]        ld_idx_num,
    output logic [PE_NUM-1:0] ld_mask,
    input  logic              ld_done,

    output logic              job_done,
    output logic              busy,
    output logic              err_timeout,
    output logic [15:0]       job_cnt
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_CMD,
        S_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [4:0]          len_q, len_d;
    logic [3:0]          mode_q, mode_d;
    logic [7:0]          idx_q, idx_d;
    logic [PE_NUM-1:0]   mask_q, mask_d;
    logic [CW-1:0]       wcnt_q, wcnt_d;
    logic                zdone_q, zdone_d;
    logic                err_q, err_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            mode_q  <= '0;
            idx_q   <= '0;
            mask_q  <= '0;
            wcnt_q  <= '0;
            zdone_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            mask_q  <= mask_d;
            wcnt_q  <= wcnt_d;
            zdone_q <= zdone_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        mode_d       = mode_q;
        idx_d        = idx_q;
        mask_d       = mask_q;
        wcnt_d       = wcnt_q;
        zdone_d      = 1'b0;
        err_d        = err_q;
        cnt_d        = cnt_q;
        job_ready    = 1'b0;
        accept       = 1'b0;
        ld_start     = 1'b0;
        rd_cmd_valid = 1'b0;
        // An empty-mask job completes one cycle after acceptance, from IDLE.
        job_done     = zdone_q;

        case (state_q)
            S_IDLE: begin
                // Hold off acceptance while an empty-mask completion is still pulsing.
                job_ready = !zdone_q;
                accept    = job_valid && !zdone_q;
                if (accept) begin
                    addr_d = job_addr;
                    len_d  = 5'(job_idx_num / 8'(IDX_BATCH) + 8'd1);
                    mode_d = job_mode;
                    idx_d  = job_idx_num;
                    mask_d = job_mask;
                    if (job_mask == '0) zdone_d = 1'b1;
                    else                state_d = S_START;
                end
            end
            S_START: begin
                ld_start = 1'b1;
                state_d  = S_CMD;
            end
            S_CMD: begin
                rd_cmd_valid = 1'b1;
                if (rd_cmd_ready) begin
                    state_d = S_WAIT;
                    wcnt_d  = '0;
                end
            end
            S_WAIT: begin
                // ld_done is checked first so it wins over a coincident timeout.
                if (ld_done) begin
                    job_done = 1'b1;
                    state_d  = S_IDLE;
                end else if (wcnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (job_done) cnt_d = cnt_q + 16'd1;
    end

    assign rd_cmd_addr = addr_q;
    assign rd_cmd_len  = len_q;
    assign ld_mode     = mode_q;
    assign ld_idx_num  = idx_q;
    assign ld_mask     = mask_q;
    assign busy        = (state_q != S_IDLE);
    assign err_timeout = err_q;
    assign job_cnt     = cnt_q;

endmodule

// File: tb/tb_idx_load_sched.sv
// Directed bench for idx_load_sched: job flow, length math, back-pressure,
// empty mask, timeout and reset behaviour, all against hand-computed values.
module tb_idx_load_sched;

    localparam int PE_NUM = 32;
    localparam int AW     = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              job_valid;
    logic              job_ready;
    logic [AW-1:0]     job_addr;
    logic [3:0]        job_mode;
    logic [7:0]        job_idx_num;
    logic [PE_NUM-1:0] job_mask;
    logic              rd_cmd_valid;
    logic              rd_cmd_ready;
    logic [AW-1:0]     rd_cmd_addr;
    logic [4:0]        rd_cmd_len;
    logic              ld_start;
    logic [3:0]        ld_mode;
    logic [7:0]        ld_idx_num;
    logic [PE_NUM-1:0] ld_mask;
    logic              ld_done;
    logic              job_done;
    logic              busy;
    logic              err_timeout;
    logic [15:0]       job_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int done_pulses = 0;
    int base;

    idx_load_sched #(
        .PE_NUM(PE_NUM), .IDX_BATCH(16), .AW(AW), .TIMEOUT(64)
    ) dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready), .job_addr(job_addr),
        .job_mode(job_mode), .job_idx_num(job_idx_num), .job_mask(job_mask),
        .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready),
        .rd_cmd_addr(rd_cmd_addr), .rd_cmd_len(rd_cmd_len),
        .ld_start(ld_start), .ld_mode(ld_mode), .ld_idx_num(ld_idx_num),
        .ld_mask(ld_mask), .ld_done(ld_done),
        .job_done(job_done), .busy(busy), .err_timeout(err_timeout), .job_cnt(job_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (job_done === 1'b1) done_pulses++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [AW-1:0] a, input logic [7:0] idx, input logic [PE_NUM-1:0] m);
        job_valid   = 1'b1;
        job_addr    = a;
        job_idx_num = idx;
        job_mask    = m;
        job_mode    = 4'h2;
    endtask

    // Full job with ld_done already high: it must be ignored until WAIT.
    task automatic run_len(input logic [7:0] idx, input logic [4:0] exp_len);
        ld_done      = 1'b1;
        rd_cmd_ready = 1'b1;
        offer(32'h0000_3000, idx, 32'h1);
        tick();
        job_valid = 1'b0;
        chk("len_start", ld_start, 1'b1);
        tick();
        chk("len_val", rd_cmd_valid, 1'b1);
        chk("len_len", rd_cmd_len, exp_len);
        tick();
        chk("len_done", job_done, 1'b1);
        tick();
        chk("len_idle", busy, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        job_valid = 1'b0; job_addr = '0; job_mode = '0; job_idx_num = '0; job_mask = '0;
        rd_cmd_ready = 1'b0; ld_done = 1'b1;
        repeat (3) tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_val", rd_cmd_valid, 1'b0);
        chk("rst_start", ld_start, 1'b0);
        chk("rst_done", job_done, 1'b0);
        chk("rst_err", err_timeout, 1'b0);
        chk("rst_cnt", job_cnt, 16'd0);
        chk("rst_mask", ld_mask, 32'd0);
        chk("rst_addr", rd_cmd_addr, 32'd0);
        chk("rst_len", rd_cmd_len, 5'd0);
        rst = 1'b0;
        tick();
        chk("idle_ready", job_ready, 1'b1);

        // Basic job: addr 0x1000, idx 37, mask 0xF, ld_done low for 20 cycles.
        rd_cmd_ready = 1'b1;
        offer(32'h0000_1000, 8'd37, 32'hF);
        job_mode = 4'h5;
        #1 chk("b_ready", job_ready, 1'b1);
        tick();
        job_valid = 1'b0; ld_done = 1'b0;
        chk("b_start", ld_start, 1'b1);
        chk("b_noval", rd_cmd_valid, 1'b0);
        chk("b_mask", ld_mask, 32'hF);
        chk("b_idx", ld_idx_num, 8'd37);
        chk("b_mode", ld_mode, 4'h5);
        chk("b_nordy", job_ready, 1'b0);
        tick();
        chk("b_val", rd_cmd_valid, 1'b1);
        chk("b_addr", rd_cmd_addr, 32'h1000);
        chk("b_len", rd_cmd_len, 5'd3);
        chk("b_start0", ld_start, 1'b0);
        tick();
        chk("b_wait_val", rd_cmd_valid, 1'b0);
        chk("b_wait_busy", busy, 1'b1);
        base = done_pulses;
        offer(32'hDEAD_0000, 8'd1, 32'hAA);
        repeat (18) begin
            chk("b_nodone", job_done, 1'b0);
            tick();
        end
        job_valid = 1'b0; ld_done = 1'b1;
        #1 chk("b_done", job_done, 1'b1);
        chk("b_hold_mask", ld_mask, 32'hF);
        tick();
        chk("b_done_off", job_done, 1'b0);
        chk("b_idle", busy, 1'b0);
        chk("b_cnt", job_cnt, 16'd1);
        chk("b_pulses", done_pulses - base, 1);

        // Length boundaries.
        run_len(8'd15, 5'd1);
        run_len(8'd16, 5'd2);
        run_len(8'd255, 5'd16);
        chk("len_cnt", job_cnt, 16'd4);

        // Back-pressure on the read command with ld_done high throughout.
        rd_cmd_ready = 1'b0;
        offer(32'h2000_0040, 8'd100, 32'h1);
        tick();
        job_valid = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("bp_val", rd_cmd_valid, 1'b1);
            chk("bp_addr", rd_cmd_addr, 32'h2000_0040);
            chk("bp_len", rd_cmd_len, 5'd7);
            tick();
        end
        rd_cmd_ready = 1'b1;
        #1 chk("bp_hs", rd_cmd_valid, 1'b1);
        tick();
        chk("bp_wait_val", rd_cmd_valid, 1'b0);
        chk("bp_wait_busy", busy, 1'b1);
        chk("bp_done", job_done, 1'b1);
        tick();
        chk("bp_cnt", job_cnt, 16'd5);

        // Empty mask completes from IDLE with no loader or DDR activity.
        offer(32'h0000_4000, 8'd9, 32'h0);
        tick();
        job_valid = 1'b0;
        chk("z_done", job_done, 1'b1);
        chk("z_start", ld_start, 1'b0);
        chk("z_val", rd_cmd_valid, 1'b0);
        chk("z_busy", busy, 1'b0);
        chk("z_nordy", job_ready, 1'b0);
        tick();
        chk("z_done_off", job_done, 1'b0);
        chk("z_cnt", job_cnt, 16'd6);
        chk("z_ready", job_ready, 1'b1);

        // Timeout: ld_done stuck low for 64 WAIT cycles.
        ld_done = 1'b0;
        base = done_pulses;
        offer(32'h0000_5000, 8'd0, 32'h3);
        tick();
        job_valid = 1'b0;
        tick();
        chk("t_len", rd_cmd_len, 5'd1);
        tick();
        repeat (63) tick();
        chk("t_busy63", busy, 1'b1);
        chk("t_err63", err_timeout, 1'b0);
        tick();
        chk("t_idle", busy, 1'b0);
        chk("t_err", err_timeout, 1'b1);
        chk("t_cnt", job_cnt, 16'd6);
        chk("t_nodone", done_pulses - base, 0);
        run_len(8'd47, 5'd3);
        chk("t_err_sticky", err_timeout, 1'b1);
        chk("t_cnt2", job_cnt, 16'd7);

        // Reset in WAIT.
        ld_done = 1'b0; rd_cmd_ready = 1'b1;
        offer(32'h0000_6000, 8'd20, 32'h1);
        tick();
        job_valid = 1'b0;
        tick();
        tick();
        chk("rw_busy_pre", busy, 1'b1);
        rst = 1'b1;
        tick();
        chk("rw_busy", busy, 1'b0);
        chk("rw_val", rd_cmd_valid, 1'b0);
        chk("rw_cnt", job_cnt, 16'd0);
        chk("rw_err", err_timeout, 1'b0);
        rst = 1'b0;
        tick();
        chk("rw_ready", job_ready, 1'b1);

        // Reset in CMD drops the command.
        rd_cmd_ready = 1'b0;
        offer(32'h0000_7000, 8'd20, 32'h1);
        tick();
        job_valid = 1'b0;
        tick();
        chk("rc_val_pre", rd_cmd_valid, 1'b1);
        rst = 1'b1;
        tick();
        chk("rc_val", rd_cmd_valid, 1'b0);
        chk("rc_busy", busy, 1'b0);
        chk("rc_mask", ld_mask, 32'd0);
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/idx_load_sched.md
IDX_LOAD_SCHED -- requirements
Module: idx_load_sched

Interface
REQ-001 SHALL have parameter PE_NUM, default 32, number of PE index buffers addressed by the mask.
REQ-002 SHALL have parameter IDX_BATCH, default 16, index pairs per DDR beat (DDR_W / IDX_W / 2).
REQ-003 SHALL have parameter AW, default 32, DDR byte-address width.
REQ-004 SHALL have parameter TIMEOUT, default 4096, maximum cycles allowed in WAIT.
REQ-005 clk  input  1  clock; all logic on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 job_valid  input  1  load job offered.
REQ-008 job_ready  output  1  job accepted when job_valid && job_ready.
REQ-009 job_addr  input  AW  DDR start address of the index list.
REQ-010 job_mode  input  4  layer mode forwarded to the loader.
REQ-011 job_idx_num  input  8  last index number; the loader writes job_idx_num+1 entries.
REQ-012 job_mask  input  PE_NUM  target PE buffers.
REQ-013 rd_cmd_valid  output  1  DDR read command valid.
REQ-014 rd_cmd_ready  input  1  DDR read command accepted.
REQ-015 rd_cmd_addr  output  AW  read start address.
REQ-016 rd_cmd_len  output  5  read length in beats.
REQ-017 ld_start  output  1  one-cycle start pulse to the index loader.
REQ-018 ld_mode, ld_idx_num, ld_mask  output  4/8/PE_NUM  loader configuration, held stable from START until IDLE.
REQ-019 ld_done  input  1  loader done level; high when the loader is idle.
REQ-020 job_done  output  1  one-cycle pulse on job completion.
REQ-021 busy  output  1  high whenever state != IDLE.
REQ-022 err_timeout  output  1  sticky timeout flag.
REQ-023 job_cnt  output  16  completed-job counter.

Function
REQ-024 SHALL implement states IDLE, START, CMD, WAIT.
REQ-025 In IDLE, job_ready SHALL be 1; it SHALL be 0 in all other states.
REQ-026 On acceptance, SHALL register all job fields; go to START, or complete immediately (job_done next cycle, stay IDLE) if job_mask == 0.
REQ-027 START SHALL last exactly 1 cycle with ld_start=1, then go to CMD.
REQ-028 In CMD, rd_cmd_valid SHALL be 1 with addr/len stable until rd_cmd_ready is sampled high, then go to WAIT.
REQ-029 rd_cmd_len SHALL equal floor(job_idx_num / IDX_BATCH) + 1 (range 1..16).
REQ-030 The DDR command SHALL never be issued before ld_start, so loader counters are cleared before the first beat arrives.
REQ-031 ld_done SHALL be ignored in START and CMD.
REQ-032 In WAIT, ld_done=1 SHALL cause a return to IDLE with a job_done pulse in the same transition cycle; job_cnt SHALL increment and wrap at 0xFFFF->0.
REQ-033 WAIT SHALL count cycles; on reaching TIMEOUT, it SHALL set err_timeout, go to IDLE, and not pulse job_done or increment job_cnt.
REQ-034 If ld_done and the timeout occur in the same cycle, ld_done SHALL win.
REQ-035 A new job SHALL be accepted in the cycle after job_done at the earliest, with no back-to-back overlap.
REQ-036 job_valid while not ready SHALL be ignored; fields are not sampled.

Reset
REQ-037 rst SHALL force IDLE regardless of state, including mid-CMD or mid-WAIT, and drop rd_cmd_valid on the next edge.
REQ-038 Reset values: job_ready=1 once in IDLE; rd_cmd_valid=0; ld_start=0; job_done=0; busy=0; err_timeout=0; job_cnt=0; ld_*/rd_cmd_addr/rd_cmd_len=0.
REQ-039 err_timeout SHALL be cleared only by rst.

Verification
REQ-040 Job addr=0x1000, idx_num=37, mask=0xF, rd_cmd_ready=1, ld_done falls then rises 20 cycles later -> ld_start at cycle 1, rd_cmd len=3 addr=0x1000, one job_done, job_cnt=1.
REQ-041 idx_num=15 and idx_num=16 -> len=1 and len=2; idx_num=255 -> len=16.
REQ-042 rd_cmd_ready held low 10 cycles -> rd_cmd_valid/addr/len stable for 10 cycles; WAIT entered after the handshake.
REQ-043 mask=0 -> no ld_start, no rd_cmd_valid; job_done 1 cycle after acceptance.
REQ-044 ld_done stuck low, TIMEOUT=64 -> err_timeout=1 after 64 WAIT cycles, no job_done, IDLE; next job proceeds normally with err_timeout still 1.
REQ-045 rst asserted in WAIT -> next cycle busy=0, rd_cmd_valid=0, job_cnt=0, err_timeout=0.
